cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the three Tomasulo result producers: add/sub unit, mul/div unit, load unit.
- Each producer hands over a finished result (ROB tag plus value) through a one-entry holding slot.
- Each cycle the block round-robins among occupied slots and broadcasts one result on a registered CDB. That CDB feeds the reservation stations, register bank ROB-tag match and the ROB.
- A flush input discards in-flight results on branch mispredict.

Parameters:
- DATA_W, 16, width of the result value.
- TAG_W, 3, width of the ROB index tag (8-entry ROB).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk1  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all held results.
- add_valid  input  1  add/sub unit offers a result.
- add_tag  input  TAG_W  ROB index of that result.
- add_data  input  DATA_W  result value.
- add_ready  output  1  add slot can accept this cycle.
- mul_valid, mul_tag, mul_data, mul_ready  same as add_*, for the mul/div unit.
- ld_valid, ld_tag, ld_data, ld_ready  same as add_*, for the load unit.
- cdb_valid  output  1  CDB carries a result this cycle.
- cdb_tag  output  TAG_W  broadcast ROB index.
- cdb_data  output  DATA_W  broadcast value.
- cdb_src  output  2  source of the broadcast: 0=add, 1=mul, 2=ld.
- conflict_cnt  output  CNT_W  saturating count of cycles with at least 2 occupied slots.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All three slots empty.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, conflict_cnt=0.
  - Round-robin last-grant pointer = 2, so add has highest priority first.
  - Releasing reset mid-operation loses all held results; producers must re-offer them.
- Slot / handshake:
  - Source index order: add=0, mul=1, ld=2.
  - x_ready = !flush && (slot_x empty || slot_x granted this cycle).
  - A transfer occurs when x_valid && x_ready at a rising edge; tag and data are captured into slot_x.
  - ready depends only on registered state and flush, never on x_valid, so there is no combinational loop.
  - A source may keep valid high on consecutive cycles and sustain one result per cycle while it wins arbitration.
- Arbitration (combinational, among occupied slots only):
  - Priority order starts at (last+1) mod 3 and wraps.
  - At most one grant per cycle.
  - On a grant, the granted slot clears at the edge (unless refilled the same edge) and last = granted index.
  - With no occupied slot, no grant and last unchanged.
- CDB output (registered):
  - At the edge ending a grant cycle: cdb_valid=1 and cdb_tag/cdb_data/cdb_src take the granted slot's contents.
  - With no grant: cdb_valid=0; tag/data/src hold their last values.
  - Latency: result accepted at edge N is broadcast at edge N+1 at the earliest (visible cycle N+1 to N+2).
  - Worst case: broadcast at edge N+3 when all three slots are occupied.
- Flush (synchronous, evaluated at the edge):
  - All slots cleared and any offer that cycle is dropped (ready=0).
  - No grant is made, so cdb_valid=0 the following cycle. A cdb_valid already registered before the flush edge is still visible during the flush cycle.
  - last pointer and conflict_cnt unchanged.
  - flush has priority over reset release only in the sense that reset is asynchronous and always wins.
- conflict_cnt:
  - Increments by 1 at each non-flush edge where at least 2 slots are occupied.
  - Saturates at 2^CNT_W-1; cleared only by reset.
- Tags are passed through unchecked. Duplicate tags from different sources are broadcast in arbitration order without merging.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with slots full -> outputs immediately cdb_valid=0, conflict_cnt=0, all x_ready=1 after release.
- Single source: add offers tag=3 data=16'h00A5 at edge 1 -> cdb_valid=1, tag=3, data=16'h00A5, src=0 after edge 2; cdb_valid=0 after edge 3.
- Three-way contention: after reset, all three valid at edge 1 with tags 1/2/4 -> broadcasts after edges 2, 3, 4 in order src 0, 1, 2; ready low for mul and ld while they wait; conflict_cnt=2.
- Fairness under continuous pressure: add and mul valid every cycle for 10 cycles -> srcs strictly alternate 0,1,0,1…; neither starves.
- Flush: mul and ld slots full, flush=1 for one cycle with add_valid=1 -> no add capture, next cycle cdb_valid=0, slots empty, last pointer unchanged.
- Saturation: hold two sources valid for 300 cycles with CNT_W=8 -> conflict_cnt stops at 255.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                               |
// | Description : Round-robin arbiter placing one result per cycle from the |
// |               add, mul and load units onto a registered common data bus |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  output logic              add_ready,
  input  logic              mul_valid,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  output logic              mul_ready,
  input  logic              ld_valid,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        cdb_src,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int NSRC = 3;

  // Producer-side signals gathered into arrays indexed add=0, mul=1, ld=2.
  logic [NSRC-1:0]   in_valid;
  logic [TAG_W-1:0]  in_tag  [NSRC];
  logic [DATA_W-1:0] in_data [NSRC];
  logic [NSRC-1:0]   ready;

  // Holding slots and round-robin state.
  logic [NSRC-1:0]   occ;
  logic [TAG_W-1:0]  slot_tag  [NSRC];
  logic [DATA_W-1:0] slot_data [NSRC];
  logic [1:0]        last;

  // Arbitration results.
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [NSRC-1:0]   gnt_vec;
  logic              multi_occ;

  assign in_valid   = {ld_valid, mul_valid, add_valid};
  assign in_tag[0]  = add_tag;
  assign in_tag[1]  = mul_tag;
  assign in_tag[2]  = ld_tag;
  assign in_data[0] = add_data;
  assign in_data[1] = mul_data;
  assign in_data[2] = ld_data;

  assign add_ready = ready[0];
  assign mul_ready = ready[1];
  assign ld_ready  = ready[2];

  assign multi_occ = (occ[0] & occ[1]) | (occ[0] & occ[2]) | (occ[1] & occ[2]);

  // Round-robin pick among occupied slots, starting just after the last winner.
  always_comb begin
    logic [1:0] cur;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    gnt_vec = '0;
    cur     = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < NSRC; k++) begin
      if (!flush && !gnt_any && occ[cur]) begin
        gnt_any      = 1'b1;
        gnt_idx      = cur;
        gnt_vec[cur] = 1'b1;
      end
      cur = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    end
  end

  // A slot accepts when empty or being drained this cycle; never depends on valid.
  for (genvar i = 0; i < NSRC; i++) begin : g_ready
    assign ready[i] = !flush && (!occ[i] || gnt_vec[i]);
  end

  // Slot capture/drain, CDB register, round-robin pointer and conflict counter.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      occ          <= '0;
      last         <= 2'd2;
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      cdb_src      <= 2'd0;
      conflict_cnt <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush) begin
      occ       <= '0;
      cdb_valid <= 1'b0;
    end else begin
      if (multi_occ && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= slot_tag[gnt_idx];
        cdb_data <= slot_data[gnt_idx];
        cdb_src  <= gnt_idx;
        last     <= gnt_idx;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (in_valid[i] && ready[i]) begin
          occ[i]       <= 1'b1;
          slot_tag[i]  <= in_tag[i];
          slot_data[i] <= in_data[i];
        end else if (gnt_vec[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cdb_arbiter                                            |
// | Description : Self-checking bench for cdb_arbiter with reference model  |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_cdb_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        add_valid, mul_valid, ld_valid;
  logic [2:0]  add_tag, mul_tag, ld_tag;
  logic [15:0] add_data, mul_data, ld_data;
  logic        add_ready, mul_ready, ld_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [7:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: what each slot holds, who won last, what the bus shows.
  logic        m_occ  [3];
  logic [2:0]  m_tag  [3];
  logic [15:0] m_data [3];
  int          m_last;
  logic        m_cdb_valid;
  logic [2:0]  m_cdb_tag;
  logic [15:0] m_cdb_data;
  int          m_cdb_src;
  int          m_cnt;

  cdb_arbiter #(.DATA_W(16), .TAG_W(3), .CNT_W(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .add_valid(add_valid), .add_tag(add_tag), .add_data(add_data), .add_ready(add_ready),
    .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data), .mul_ready(mul_ready),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data), .ld_ready(ld_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_occ[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_last = 2; m_cdb_valid = 1'b0; m_cdb_tag = '0; m_cdb_data = '0;
    m_cdb_src = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    add_valid = 1'b0; mul_valid = 1'b0; ld_valid = 1'b0;
    add_tag = '0; mul_tag = '0; ld_tag = '0;
    add_data = '0; mul_data = '0; ld_data = '0;
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic do_reset(input bit check_now);
    @(negedge clk1);
    #2 rst_n = 1'b0;
    idle_inputs();
    #1;
    if (check_now) begin
      check_eq("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check_eq("rst_conflict", {24'd0, conflict_cnt}, 32'd0);
      check_eq("rst_cdb_tag", {29'd0, cdb_tag}, 32'd0);
      check_eq("rst_cdb_data", {16'd0, cdb_data}, 32'd0);
    end
    model_reset();
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    if (check_now) begin
      check_eq("rst_ready", {29'd0, ld_ready, mul_ready, add_ready}, 32'd7);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance model.
  task automatic drive_cycle(input logic av, input logic [2:0] at, input logic [15:0] ad,
                             input logic mv, input logic [2:0] mt, input logic [15:0] md,
                             input logic lv, input logic [2:0] lt, input logic [15:0] ld,
                             input logic fl);
    logic        v   [3];
    logic [2:0]  t   [3];
    logic [15:0] d   [3];
    logic        rdy [3];
    int          gnt;
    int          n;
    @(negedge clk1);
    check_eq("cdb_valid", {31'd0, cdb_valid}, {31'd0, m_cdb_valid});
    if (m_cdb_valid) begin
      check_eq("cdb_tag", {29'd0, cdb_tag}, {29'd0, m_cdb_tag});
      check_eq("cdb_data", {16'd0, cdb_data}, {16'd0, m_cdb_data});
      check_eq("cdb_src", {30'd0, cdb_src}, m_cdb_src);
    end
    check_eq("conflict_cnt", {24'd0, conflict_cnt}, m_cnt);
    v[0] = av; t[0] = at; d[0] = ad;
    v[1] = mv; t[1] = mt; d[1] = md;
    v[2] = lv; t[2] = lt; d[2] = ld;
    add_valid = av; add_tag = at; add_data = ad;
    mul_valid = mv; mul_tag = mt; mul_data = md;
    ld_valid = lv; ld_tag = lt; ld_data = ld;
    flush = fl;
    gnt = -1;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_last + k) % 3;
      if (!fl && gnt < 0 && m_occ[idx]) gnt = idx;
    end
    for (int x = 0; x < 3; x++) begin
      rdy[x] = !fl && (!m_occ[x] || gnt == x);
      if (m_occ[x]) n++;
    end
    #1;
    check_eq("ready", {29'd0, ld_ready, mul_ready, add_ready},
             {29'd0, rdy[2], rdy[1], rdy[0]});
    @(posedge clk1);
    if (fl) begin
      for (int x = 0; x < 3; x++) m_occ[x] = 1'b0;
      m_cdb_valid = 1'b0;
    end else begin
      if (n >= 2 && m_cnt < 255) m_cnt++;
      if (gnt >= 0) begin
        m_cdb_valid = 1'b1;
        m_cdb_tag   = m_tag[gnt];
        m_cdb_data  = m_data[gnt];
        m_cdb_src   = gnt;
        m_last      = gnt;
        m_occ[gnt]  = 1'b0;
      end else begin
        m_cdb_valid = 1'b0;
      end
      for (int x = 0; x < 3; x++) begin
        if (v[x] && rdy[x]) begin
          m_occ[x] = 1'b1; m_tag[x] = t[x]; m_data[x] = d[x];
        end
      end
    end
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;

    // Single source
    drive_cycle(1'b1, 3'd3, 16'h00A5, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    idle_cycle();
    #1;
    check_eq("single_valid", {31'd0, cdb_valid}, 32'd1);
    check_eq("single_tag", {29'd0, cdb_tag}, 32'd3);
    check_eq("single_data", {16'd0, cdb_data}, 32'h00A5);
    check_eq("single_src", {30'd0, cdb_src}, 32'd0);
    idle_cycle();
    #1;
    check_eq("single_done", {31'd0, cdb_valid}, 32'd0);

    // Three-way contention from a fresh reset
    do_reset(1'b0);
    drive_cycle(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd4, 16'h4444, 1'b0);
    for (int s = 0; s < 3; s++) begin
      idle_cycle();
      #1;
      check_eq("three_src", {30'd0, cdb_src}, s);
      check_eq("three_tag", {29'd0, cdb_tag}, (s == 2) ? 32'd4 : s + 1);
    end
    check_eq("three_conflict", {24'd0, conflict_cnt}, 32'd2);

    // Flush with mul and ld occupied; add offer is dropped, pointer kept
    do_reset(1'b0);
    drive_cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd6, 16'h6666, 1'b0);
    drive_cycle(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    #1;
    check_eq("flush_cdb", {31'd0, cdb_valid}, 32'd0);
    idle_cycle();
    #1;
    check_eq("flush_empty", {31'd0, cdb_valid}, 32'd0);
    drive_cycle(1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b0, 3'd0, 16'd0, 1'b0);
    idle_cycle();
    #1;
    check_eq("flush_last_kept", {30'd0, cdb_src}, 32'd0);
    idle_cycle();
    idle_cycle();

    // Async reset mid-cycle with slots full
    drive_cycle(1'b1, 3'd1, 16'hB001, 1'b1, 3'd2, 16'hB002, 1'b1, 3'd3, 16'hB003, 1'b0);
    do_reset(1'b1);

    // Sustained add+mul pressure: alternation and counter saturation
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'($urandom), 16'($urandom),
                  1'b0, 3'd0, 16'd0, 1'b0);
    end
    idle_cycle();
    #1;
    check_eq("saturate", {24'd0, conflict_cnt}, 32'd255);

    // Randomized traffic with occasional flush and one mid-run reset
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1'b1);
      drive_cycle($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 50, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 40, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 5);
    end
    idle_cycle();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
